// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU sequencer.
// Opcodes, ALU codes, FSM states and the decoded-instruction bundle.
package cpu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_INV  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_MOV  = 4'h7;
   localparam logic [3:0] OP_LOAD = 4'h8;
   localparam logic [3:0] OP_JZ   = 4'h9;
   localparam logic [3:0] OP_INC  = 4'hA;
   localparam logic [3:0] OP_DEC  = 4'hB;
   localparam logic [3:0] OP_HLT  = 4'hC;
   localparam logic [3:0] OP_JC   = 4'hD;
   localparam logic [3:0] OP_JNZ  = 4'hE;
   localparam logic [3:0] OP_JMP  = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_INV = 3'b101;
   localparam logic [2:0] ALU_SHL = 3'b111;

   localparam logic [2:0] FLAG_ADDR = 3'd7;
   localparam logic [7:0] FLAG_C    = 8'h80;
   localparam logic [7:0] FLAG_Z    = 8'h40;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_RD_A, S_RD_B, S_EXEC,
      S_WB, S_WB_FLAG, S_BRANCH, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      BR_NONE, BR_JMP, BR_JNZ, BR_JC, BR_JZ, BR_HLT
   } br_t;

   typedef enum logic [1:0] {
      WS_ALU, WS_IMM, WS_A
   } wsel_t;

   typedef struct packed {
      logic       rd_a;
      logic [2:0] a_addr;
      logic       rd_b;
      logic [2:0] b_addr;
      logic [7:0] b_const;
      logic       exec;
      logic [2:0] alu_op;
      logic       wb;
      wsel_t      wsel;
      logic       flag_wr;
      br_t        br;
   } dec_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decode: operand-read plan, ALU op,
// writeback/flag enables and branch type.
module cpu_decode
   import cpu_pkg::*;
(
   input  logic [3:0] op,
   input  logic [1:0] dst,
   input  logic [1:0] src_a,
   input  logic [1:0] src_b,
   output dec_t       dec
);

   always_comb begin
      dec      = '0;
      dec.wsel = WS_ALU;
      dec.br   = BR_NONE;
      unique case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            dec.rd_a    = 1'b1;
            dec.a_addr  = {1'b0, src_a};
            dec.rd_b    = 1'b1;
            dec.b_addr  = {1'b0, src_b};
            dec.exec    = 1'b1;
            dec.alu_op  = op[2:0];
            dec.wb      = 1'b1;
            dec.flag_wr = 1'b1;
         end
         OP_INV: begin
            dec.rd_a    = 1'b1;
            dec.a_addr  = {1'b0, src_a};
            dec.exec    = 1'b1;
            dec.alu_op  = ALU_INV;
            dec.wb      = 1'b1;
            dec.flag_wr = 1'b1;
         end
         OP_SHL: begin
            dec.rd_a    = 1'b1;
            dec.a_addr  = {1'b0, dst};
            dec.rd_b    = 1'b1;
            dec.b_addr  = {1'b0, src_a};
            dec.exec    = 1'b1;
            dec.alu_op  = ALU_SHL;
            dec.wb      = 1'b1;
            dec.flag_wr = 1'b1;
         end
         OP_INC, OP_DEC: begin
            dec.rd_a    = 1'b1;
            dec.a_addr  = {1'b0, dst};
            dec.b_const = 8'h01;
            dec.exec    = 1'b1;
            dec.alu_op  = (op == OP_INC) ? ALU_ADD : ALU_SUB;
            dec.wb      = 1'b1;
            dec.flag_wr = 1'b1;
         end
         OP_LOAD: begin
            dec.wb   = 1'b1;
            dec.wsel = WS_IMM;
         end
         OP_MOV: begin
            dec.rd_a   = 1'b1;
            dec.a_addr = {1'b0, src_a};
            dec.wb     = 1'b1;
            dec.wsel   = WS_A;
         end
         OP_JMP: dec.br = BR_JMP;
         OP_JNZ: begin
            dec.rd_a   = 1'b1;
            dec.a_addr = {1'b0, dst};
            dec.br     = BR_JNZ;
         end
         OP_JC: begin
            dec.rd_a   = 1'b1;
            dec.a_addr = FLAG_ADDR;
            dec.br     = BR_JC;
         end
         OP_JZ: begin
            dec.rd_a   = 1'b1;
            dec.a_addr = FLAG_ADDR;
            dec.br     = BR_JZ;
         end
         OP_HLT: dec.br = BR_HLT;
         default: dec.br = BR_HLT;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch-decode-execute FSM for the 8-bit processor; owns the PC,
// IR and the ALU operand/result registers.
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] pc,
   output logic            ir_en,
   input  logic [15:0]     ir_data,
   output logic [2:0]      reg_addr,
   output logic            reg_rd,
   output logic            reg_wr,
   output logic [7:0]      reg_wdata,
   input  logic [7:0]      reg_rdata,
   output logic [2:0]      alu_op,
   output logic [7:0]      alu_a,
   output logic [7:0]      alu_b,
   input  logic [7:0]      alu_out,
   input  logic            alu_cy,
   input  logic            alu_zero,
   output logic            halted
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [7:0]      a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]      op_q, op_d;
   logic            cy_q, cy_d, z_q, z_d;
   logic            ir_en_c, reg_rd_c, reg_wr_c;
   logic            taken;
   logic [PC_W-1:0] target, pc_inc;
   dec_t            dec;
   logic            unused_ir;

   assign unused_ir = ^ir_q[11:10];
   assign target    = PC_W'(ir_q[7:0]);
   assign pc_inc    = pc_q + PC_W'(1);

   cpu_decode u_decode (
      .op    (ir_q[15:12]),
      .dst   (ir_q[9:8]),
      .src_a (ir_q[5:4]),
      .src_b (ir_q[1:0]),
      .dec   (dec)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      res_d     = res_q;
      cy_d      = cy_q;
      z_d       = z_q;
      ir_en_c   = 1'b0;
      reg_rd_c  = 1'b0;
      reg_wr_c  = 1'b0;
      reg_addr  = '0;
      reg_wdata = '0;
      taken     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ir_en_c = 1'b1;
            ir_d    = ir_data;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (dec.exec) begin
               op_d = dec.alu_op;
               b_d  = dec.b_const;
            end
            if (dec.br == BR_JMP) begin
               pc_d    = target;
               state_d = S_FETCH;
            end else if (dec.br == BR_HLT) begin
               state_d = S_HALT;
            end else if (dec.rd_a) begin
               state_d = S_RD_A;
            end else begin
               state_d = S_WB;
            end
         end
         S_RD_A: begin
            reg_rd_c = 1'b1;
            reg_addr = dec.a_addr;
            a_d      = reg_rdata;
            if (dec.br != BR_NONE)  state_d = S_BRANCH;
            else if (dec.rd_b)      state_d = S_RD_B;
            else if (dec.exec)      state_d = S_EXEC;
            else                    state_d = S_WB;
         end
         S_RD_B: begin
            reg_rd_c = 1'b1;
            reg_addr = dec.b_addr;
            b_d      = reg_rdata;
            state_d  = S_EXEC;
         end
         S_EXEC: begin
            res_d   = alu_out;
            cy_d    = alu_cy;
            z_d     = alu_zero;
            state_d = S_WB;
         end
         S_WB: begin
            reg_wr_c = 1'b1;
            reg_addr = {1'b0, ir_q[9:8]};
            unique case (dec.wsel)
               WS_IMM:  reg_wdata = ir_q[7:0];
               WS_A:    reg_wdata = a_q;
               default: reg_wdata = res_q;
            endcase
            if (dec.flag_wr) begin
               state_d = S_WB_FLAG;
            end else begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end
         end
         S_WB_FLAG: begin
            reg_wr_c  = 1'b1;
            reg_addr  = FLAG_ADDR;
            reg_wdata = {cy_q, z_q, 6'b0};
            pc_d      = pc_inc;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            unique case (dec.br)
               BR_JNZ:  taken = (a_q != 8'h00);
               BR_JC:   taken = (a_q == FLAG_C);
               BR_JZ:   taken = (a_q == FLAG_Z);
               default: taken = 1'b0;
            endcase
            pc_d    = taken ? target : pc_inc;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are masked by rst so an instruction caught by reset
   // never commits a write in its final cycle.
   assign ir_en  = ir_en_c  & ~rst;
   assign reg_rd = reg_rd_c & ~rst;
   assign reg_wr = reg_wr_c & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         z_q     <= z_d;
      end
   end

   assign pc     = pc_q;
   assign alu_op = op_q;
   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a behavioural instruction
// memory, register file and ALU.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  pc;
   logic        ir_en;
   logic [15:0] ir_data;
   logic [2:0]  reg_addr;
   logic        reg_rd, reg_wr;
   logic [7:0]  reg_wdata, reg_rdata;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a, alu_b, alu_out;
   logic        alu_cy, alu_zero;
   logic        halted;

   logic [15:0] imem [256];
   logic [7:0]  regs [8];
   int          wr_count = 0;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   cpu_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .ir_en     (ir_en),
      .ir_data   (ir_data),
      .reg_addr  (reg_addr),
      .reg_rd    (reg_rd),
      .reg_wr    (reg_wr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_out   (alu_out),
      .alu_cy    (alu_cy),
      .alu_zero  (alu_zero),
      .halted    (halted)
   );

   assign ir_data   = imem[pc];
   assign reg_rdata = reg_rd ? regs[reg_addr] : 8'h00;

   always @(posedge clk) begin
      if (reg_wr) begin
         regs[reg_addr] <= reg_wdata;
         wr_count       <= wr_count + 1;
      end
   end

   logic [8:0] alu_t;
   always_comb begin
      alu_t = 9'h000;
      case (alu_op)
         3'b000:  alu_t = {1'b0, alu_a} + {1'b0, alu_b};
         3'b001:  alu_t = {1'b0, alu_a} - {1'b0, alu_b};
         3'b010:  alu_t = {1'b0, alu_a & alu_b};
         3'b011:  alu_t = {1'b0, alu_a | alu_b};
         3'b100:  alu_t = {1'b0, alu_a ^ alu_b};
         3'b101:  alu_t = {1'b0, ~alu_a};
         3'b111:  alu_t = {alu_a, 1'b0} << alu_b[2:0];
         default: alu_t = 9'h000;
      endcase
   end
   assign alu_out  = alu_t[7:0];
   assign alu_cy   = alu_t[8];
   assign alu_zero = (alu_t[7:0] == 8'h00);

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
   endtask

   // Leaves the bench just after the negedge that opens cycle 1 (FETCH).
   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_load();
      clear_mem();
      imem[0] = 16'h8005;
      do_reset();
      checks++;
      if (ir_en !== 1'b1) begin
         failures++;
         $display("FAIL load_fetch ir_en=%0b exp=1", ir_en);
      end
      run_cycles(1);
      checks++;
      if (reg_wr !== 1'b0 || ir_en !== 1'b0) begin
         failures++;
         $display("FAIL load_decode wr=%0b en=%0b exp=0/0", reg_wr, ir_en);
      end
      run_cycles(1);
      checks++;
      if (reg_wr !== 1'b1 || reg_addr !== 3'd0 || reg_wdata !== 8'd5) begin
         failures++;
         $display("FAIL load_wb wr=%0b addr=%0d data=%0h exp=1/0/5",
                  reg_wr, reg_addr, reg_wdata);
      end
      checks++;
      if (reg_rd !== 1'b0) begin
         failures++;
         $display("FAIL load_rd_wr reg_rd=%0b exp=0", reg_rd);
      end
      run_cycles(1);
      checks++;
      if (pc !== 8'd1 || ir_en !== 1'b1 || reg_wr !== 1'b0) begin
         failures++;
         $display("FAIL load_next pc=%0h en=%0b wr=%0b exp=1/1/0",
                  pc, ir_en, reg_wr);
      end
      checks++;
      if (regs[0] !== 8'd5) begin
         failures++;
         $display("FAIL load_r0 got=%0h exp=5", regs[0]);
      end
   endtask

   task automatic test_add();
      clear_mem();
      imem[0] = 16'h80C8;
      imem[1] = 16'h8164;
      imem[2] = 16'h0201;
      do_reset();
      run_cycles(6);
      checks++;
      if (pc !== 8'd2 || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL add_start pc=%0h en=%0b exp=2/1", pc, ir_en);
      end
      run_cycles(6);
      checks++;
      if (reg_wr !== 1'b1 || reg_addr !== 3'd7 || reg_wdata !== 8'h80) begin
         failures++;
         $display("FAIL add_wbflag wr=%0b addr=%0d data=%0h exp=1/7/80",
                  reg_wr, reg_addr, reg_wdata);
      end
      checks++;
      if (alu_a !== 8'd200 || alu_b !== 8'd100 || alu_op !== 3'b000) begin
         failures++;
         $display("FAIL add_operands a=%0d b=%0d op=%0d exp=200/100/0",
                  alu_a, alu_b, alu_op);
      end
      checks++;
      if (pc !== 8'd2) begin
         failures++;
         $display("FAIL add_pc_hold pc=%0h exp=2", pc);
      end
      run_cycles(1);
      checks++;
      if (pc !== 8'd3 || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL add_len pc=%0h en=%0b exp=3/1", pc, ir_en);
      end
      checks++;
      if (regs[2] !== 8'd44 || regs[7] !== 8'h80) begin
         failures++;
         $display("FAIL add_result r2=%0d f=%0h exp=44/80", regs[2], regs[7]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (pc !== 8'h00 || halted !== 1'b0) begin
         failures++;
         $display("FAIL reset_pc pc=%0h halted=%0b exp=0/0", pc, halted);
      end
      checks++;
      if (ir_en !== 1'b0 || reg_rd !== 1'b0 || reg_wr !== 1'b0) begin
         failures++;
         $display("FAIL reset_strobes en=%0b rd=%0b wr=%0b exp=0/0/0",
                  ir_en, reg_rd, reg_wr);
      end
      checks++;
      if (reg_addr !== 3'd0 || reg_wdata !== 8'h00 || alu_op !== 3'd0 ||
          alu_a !== 8'h00 || alu_b !== 8'h00) begin
         failures++;
         $display("FAIL reset_data addr=%0d wd=%0h op=%0d a=%0h b=%0h exp=0",
                  reg_addr, reg_wdata, alu_op, alu_a, alu_b);
      end
   endtask

   task automatic test_dec_jz(input logic [7:0] init, input logic [7:0] exp_r3,
                              input logic [7:0] exp_f, input logic [7:0] exp_pc);
      clear_mem();
      imem[0] = {8'h83, init};
      imem[1] = 16'hB300;
      imem[2] = 16'h9010;
      do_reset();
      run_cycles(3);
      checks++;
      if (pc !== 8'd1 || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL decjz_dec_start pc=%0h en=%0b exp=1/1", pc, ir_en);
      end
      run_cycles(6);
      checks++;
      if (pc !== 8'd2 || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL decjz_dec_len pc=%0h en=%0b exp=2/1", pc, ir_en);
      end
      run_cycles(4);
      checks++;
      if (pc !== exp_pc || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL decjz_pc pc=%0h en=%0b exp=%0h/1", pc, ir_en, exp_pc);
      end
      checks++;
      if (regs[3] !== exp_r3 || regs[7] !== exp_f) begin
         failures++;
         $display("FAIL decjz_regs r3=%0h f=%0h exp=%0h/%0h",
                  regs[3], regs[7], exp_r3, exp_f);
      end
   endtask

   task automatic test_jmp_wrap();
      clear_mem();
      imem[0]     = 16'hF0FF;
      imem[8'hFF] = 16'h8107;
      do_reset();
      run_cycles(2);
      checks++;
      if (pc !== 8'hFF || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL jmp_target pc=%0h en=%0b exp=ff/1", pc, ir_en);
      end
      run_cycles(3);
      checks++;
      if (pc !== 8'h00 || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL jmp_wrap pc=%0h en=%0b exp=0/1", pc, ir_en);
      end
      checks++;
      if (regs[1] !== 8'h07) begin
         failures++;
         $display("FAIL jmp_load r1=%0h exp=7", regs[1]);
      end
   endtask

   task automatic test_halt();
      int bad;
      clear_mem();
      imem[0] = 16'h8109;
      imem[1] = 16'hC000;
      do_reset();
      run_cycles(5);
      checks++;
      if (halted !== 1'b1 || pc !== 8'd1) begin
         failures++;
         $display("FAIL halt_enter halted=%0b pc=%0h exp=1/1", halted, pc);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ir_en !== 1'b0 || reg_wr !== 1'b0 || halted !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL halt_quiet bad_cycles=%0d exp=0", bad);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (pc !== 8'h00 || halted !== 1'b0 || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL halt_release pc=%0h halted=%0b en=%0b exp=0/0/1",
                  pc, halted, ir_en);
      end
   endtask

   task automatic test_reset_mid();
      int         wr_before;
      logic [7:0] f_before;
      clear_mem();
      imem[0] = 16'h8255;
      imem[1] = 16'h8000;
      imem[2] = 16'h8100;
      imem[3] = 16'h0201;
      do_reset();
      run_cycles(14);
      checks++;
      if (reg_wr !== 1'b1 || reg_addr !== 3'd2 || reg_wdata !== 8'h00) begin
         failures++;
         $display("FAIL mid_wb wr=%0b addr=%0d data=%0h exp=1/2/0",
                  reg_wr, reg_addr, reg_wdata);
      end
      wr_before = wr_count;
      f_before  = regs[7];
      rst = 1'b1;
      #1;
      checks++;
      if (reg_wr !== 1'b0) begin
         failures++;
         $display("FAIL mid_wr_drop wr=%0b exp=0", reg_wr);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (pc !== 8'h00 || ir_en !== 1'b1) begin
         failures++;
         $display("FAIL mid_refetch pc=%0h en=%0b exp=0/1", pc, ir_en);
      end
      checks++;
      if (wr_count !== wr_before || regs[2] !== 8'h55 || regs[7] !== f_before) begin
         failures++;
         $display("FAIL mid_nowrite wr=%0d r2=%0h f=%0h exp=%0d/55/%0h",
                  wr_count, regs[2], regs[7], wr_before, f_before);
      end
   endtask

   initial begin
      test_load();
      test_add();
      test_reset();
      test_dec_jz(8'd1, 8'd0, 8'h40, 8'h10);
      test_dec_jz(8'd2, 8'd1, 8'h00, 8'h03);
      test_jmp_wrap();
      test_halt();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
